mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its data-access requester.
- Built for the unified-memory configuration, where instruction and data memory are one physical array.
- Sequences each transfer with a request/acknowledge handshake and arbitrates round-robin between the two requesters.
- A watchdog aborts a memory transfer that never completes.

Parameters:
- TIMEOUT, 16: max cycles m_req is held without m_ack before the transfer is aborted with an error; legal range 1..255.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- i_req  in  1  fetch request, level; held until i_ack
- i_addr  in  32  fetch address, stable while i_req
- i_rdata  out  32  fetched instruction, valid while i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch timed out, valid with i_ack
- d_req  in  1  data request, level; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_mode  in  3  access mode (funct3 encoding)
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ack
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  data access timed out, valid with d_ack
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_mode  out  3  memory access mode
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid with m_ack
- m_ack  in  1  memory completes the current request this cycle

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0, state goes to IDLE, and last_grant goes to D. Reset mid-transfer drops m_req immediately and issues no ack.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, arbitration:
  - Only i_req high -> BUSY_I.
  - Only d_req high -> BUSY_D.
  - Both high -> grant the requester that is not last_grant. First tie after reset therefore goes to fetch.
  - On grant, update last_grant.
- IDLE, latching on the grant edge: register the granted requester's fields into m_*.
  - Fetch grant: m_addr = i_addr, m_we = 0, m_mode = 3'b010, m_wdata = 0.
  - Data grant: m_addr = d_addr, m_we = d_we, m_mode = d_mode, m_wdata = d_wdata.
- All m_* outputs are registered. m_req is 1 exactly in BUSY_I/BUSY_D. m_addr/m_we/m_mode/m_wdata hold stable for the whole BUSY state and clear to 0 on leaving it.
- BUSY_x: a wait counter starts at 0 on entry and increments each cycle m_ack is 0.
  - m_ack = 1 -> go to RESP_x and capture data into x_rdata: m_rdata for fetch and load, 0 for store. x_err = 0.
  - Counter reaches TIMEOUT-1 with m_ack still 0 -> go to RESP_x with x_rdata = 0 and x_err = 1.
  - m_ack and timeout in the same cycle: m_ack wins, err = 0.
- RESP_x: x_ack = 1 for exactly this cycle, then IDLE.
  - x_rdata and x_err hold their value until the next RESP of the same requester.
  - x_err is cleared when the next completion of that requester is loaded.
- Requests seen during BUSY/RESP are ignored. A requester keeps req high through its ack cycle and may re-raise it in the next cycle; the arbiter samples it in IDLE.
- m_ack while not in BUSY is ignored.
- Timing:
  - Minimum latency: req in cycle 0 -> m_req in cycle 1 -> (m_ack in cycle 1) -> ack in cycle 2.
  - Peak throughput: one transfer per 3 cycles.
- Starvation-free: with both requesters continuously requesting, grants strictly alternate I, D, I, D.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory acks in m_req's first cycle with m_rdata=0x00500093 -> m_addr=0x100, m_we=0, m_mode=010 in cycle 1; i_ack=1 with i_rdata=0x00500093 in cycle 2; i_err=0.
- Store: d_req=1, d_we=1, d_mode=010, d_addr=0x2000, d_wdata=0xDEADBEEF, m_ack after 3 wait cycles -> m_* stable for 4 cycles; d_ack pulses once; d_rdata=0.
- Contention: i_req and d_req held high continuously from reset -> grant order I, D, I, D; no two acks in the same cycle; each ack exactly 3 cycles apart with zero-wait memory.
- Timeout: TIMEOUT=4, d_req load, m_ack never asserted -> m_req high exactly 4 cycles, then d_ack=1 with d_err=1 and d_rdata=0; the next successful load clears d_err.
- Reset mid-transfer: assert reset while in BUSY_D with m_req=1 -> all outputs 0 asynchronously; no d_ack afterwards; with both requests high after release, fetch is granted first.
- Boundary: m_ack coincides with the TIMEOUT-1 cycle -> normal completion with err=0; a stray m_ack in IDLE produces no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the instruction-fetch
// and data-access requesters. Round-robin arbitration, registered memory
// interface, one-cycle completion pulse per requester, and a watchdog that
// aborts a memory request that is never acknowledged.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16  // legal range 1..255
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    // data access requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    // memory port
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_mode,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    localparam logic       GRANT_I  = 1'b0;
    localparam logic       GRANT_D  = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] MODE_WORD = 3'b010;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [2:0]  m_mode_q, m_mode_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic timed_out;
    assign timed_out = (wait_cnt_q == CNT_LAST);

    // State and datapath registers; reset drops the memory request at once.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            wait_cnt_q   <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_mode_q     <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_mode_q     <= m_mode_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_rdata_q    <= i_rdata_d;
            i_err_q      <= i_err_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    // Next state: round-robin grant in IDLE, completion or timeout in BUSY.
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && (!d_req || last_grant_q == GRANT_D)) state_d = BUSY_I;
                else if (d_req)                                   state_d = BUSY_D;
            end
            BUSY_I:  if (m_ack || timed_out) state_d = RESP_I;
            BUSY_D:  if (m_ack || timed_out) state_d = RESP_D;
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the granted request, run the watchdog, capture responses.
    always_comb begin
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_mode_d     = m_mode_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        i_err_d      = i_err_q;
        d_rdata_d    = d_rdata_q;
        d_err_d      = d_err_q;

        if (state_q == IDLE && state_d == BUSY_I) begin
            last_grant_d = GRANT_I;
            wait_cnt_d   = '0;
            m_req_d      = 1'b1;
            m_we_d       = 1'b0;
            m_mode_d     = MODE_WORD;
            m_addr_d     = i_addr;
            m_wdata_d    = '0;
        end else if (state_q == IDLE && state_d == BUSY_D) begin
            last_grant_d = GRANT_D;
            wait_cnt_d   = '0;
            m_req_d      = 1'b1;
            m_we_d       = d_we;
            m_mode_d     = d_mode;
            m_addr_d     = d_addr;
            m_wdata_d    = d_wdata;
        end else if (state_q == BUSY_I || state_q == BUSY_D) begin
            if (m_ack || timed_out) begin
                // m_ack wins over a coincident timeout
                m_req_d   = 1'b0;
                m_we_d    = 1'b0;
                m_mode_d  = '0;
                m_addr_d  = '0;
                m_wdata_d = '0;
                if (state_q == BUSY_I) begin
                    i_rdata_d = m_ack ? m_rdata : '0;
                    i_err_d   = !m_ack;
                end else begin
                    d_rdata_d = (m_ack && !m_we_q) ? m_rdata : '0;
                    d_err_d   = !m_ack;
                end
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    // Outputs: ack pulses decode the RESP states; everything else is a flop.
    always_comb begin
        i_ack   = (state_q == RESP_I);
        d_ack   = (state_q == RESP_D);
        i_rdata = i_rdata_q;
        i_err   = i_err_q;
        d_rdata = d_rdata_q;
        d_err   = d_err_q;
        m_req   = m_req_q;
        m_we    = m_we_q;
        m_mode  = m_mode_q;
        m_addr  = m_addr_q;
        m_wdata = m_wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack, i_err;
    logic        d_req, d_we;
    logic [2:0]  d_mode;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack, d_err;
    logic        m_req, m_we;
    logic [2:0]  m_mode;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_mode  (d_mode),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_mode  (m_mode),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_mode = 0; d_addr = 0; d_wdata = 0;
        m_rdata = 0; m_ack = 0;
        tick(); tick();

        // Reset state
        check("rst_m_req", 32'(m_req), 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_acks", {30'd0, i_ack, d_ack}, 0);
        check("rst_errs", {30'd0, i_err, d_err}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);

        // Single fetch, zero-wait memory
        reset = 1'b0;
        i_req = 1; i_addr = 32'h100;
        tick();
        check("fetch_m_req", 32'(m_req), 1);
        check("fetch_m_addr", m_addr, 32'h100);
        check("fetch_m_we", 32'(m_we), 0);
        check("fetch_m_mode", 32'(m_mode), 32'h2);
        m_ack = 1; m_rdata = 32'h0050_0093;
        tick();
        check("fetch_i_ack", 32'(i_ack), 1);
        check("fetch_i_rdata", i_rdata, 32'h0050_0093);
        check("fetch_i_err", 32'(i_err), 0);
        check("fetch_m_clr", {m_addr[30:0], m_req}, 0);
        m_ack = 0; i_req = 0;
        tick();
        check("fetch_ack_once", 32'(i_ack), 0);

        // Load that times out (m_ack never comes)
        d_req = 1; d_we = 0; d_mode = 3'b010; d_addr = 32'h3000; d_wdata = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("to_m_req_c%0d", k), 32'(m_req), 1);
            check($sformatf("to_no_ack_c%0d", k), 32'(d_ack), 0);
        end
        tick();
        check("to_m_req_drop", 32'(m_req), 0);
        check("to_d_ack", 32'(d_ack), 1);
        check("to_d_err", 32'(d_err), 1);
        check("to_d_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        check("to_err_hold", 32'(d_err), 1);

        // Successful load clears d_err
        d_req = 1; d_addr = 32'h3004;
        tick();
        check("ld_m_addr", m_addr, 32'h3004);
        m_ack = 1; m_rdata = 32'h1234_5678;
        tick();
        check("ld_d_ack", 32'(d_ack), 1);
        check("ld_d_rdata", d_rdata, 32'h1234_5678);
        check("ld_d_err", 32'(d_err), 0);
        m_ack = 0; d_req = 0;
        tick();

        // Store, m_ack after 3 wait cycles (coincides with TIMEOUT-1)
        d_req = 1; d_we = 1; d_mode = 3'b010; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("st_m_req_c%0d", k), 32'(m_req), 1);
            check($sformatf("st_m_we_c%0d", k), 32'(m_we), 1);
            check($sformatf("st_m_mode_c%0d", k), 32'(m_mode), 32'h2);
            check($sformatf("st_m_addr_c%0d", k), m_addr, 32'h2000);
            check($sformatf("st_m_wdata_c%0d", k), m_wdata, 32'hDEAD_BEEF);
            if (k == 4) begin
                m_ack = 1; m_rdata = 32'hFFFF_FFFF;
            end
        end
        tick();
        check("st_d_ack", 32'(d_ack), 1);
        check("st_d_rdata", d_rdata, 0);
        check("st_d_err", 32'(d_err), 0);
        check("st_m_clr", {m_addr[29:0], m_we, m_req}, 0);
        m_ack = 0; d_req = 0; d_we = 0;
        tick();
        check("st_ack_once", 32'(d_ack), 0);

        // Stray m_ack in IDLE
        m_ack = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("stray_acks_%0d", k), {30'd0, i_ack, d_ack}, 0);
            check($sformatf("stray_m_req_%0d", k), 32'(m_req), 0);
        end
        m_ack = 0;

        // Reset while BUSY_D
        d_req = 1; d_addr = 32'h4000;
        tick();
        check("rmt_m_req_c1", 32'(m_req), 1);
        tick();
        check("rmt_m_req_c2", 32'(m_req), 1);
        reset = 1'b1;
        #1;
        check("rmt_async_m_req", 32'(m_req), 0);
        check("rmt_async_m_addr", m_addr, 0);
        check("rmt_async_d_ack", 32'(d_ack), 0);
        i_req = 1; i_addr = 32'h500;
        tick();
        tick();
        check("rmt_held_acks", {30'd0, i_ack, d_ack}, 0);

        // Contention from reset with zero-wait memory: I,D,I,D, acks 3 apart
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("rr_i_ack_c%0d", k), 32'(i_ack), 32'((k % 6) == 2));
            check($sformatf("rr_d_ack_c%0d", k), 32'(d_ack), 32'((k % 6) == 5));
            if ((k % 6) == 2) check($sformatf("rr_i_rdata_c%0d", k), i_rdata, 32'hC0DE_0000 | 32'(k - 1));
            if ((k % 6) == 5) check($sformatf("rr_d_rdata_c%0d", k), d_rdata, 32'hC0DE_0000 | 32'(k - 1));
            m_ack   = m_req;
            m_rdata = 32'hC0DE_0000 | 32'(k);
        end
        i_req = 0; d_req = 0; m_ack = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
